// File: rtl/heartbeat_grant_arbiter.sv
// Round-robin grant arbiter for heartbeat period counters: emits one valid/ready event per served channel, then a one-cycle grant.
// Optional timeout on the event handshake is enabled by defining HB_ARB_TIMEOUT_EN.
module heartbeat_grant_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int SEQ_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    handshake,
    output logic [NUM_CH-1:0]    grant,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [CH_W-1:0]      evt_ch,
    output logic [SEQ_WIDTH-1:0] evt_seq,
    output logic                 evt_drop,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    if (NUM_CH < 1 || NUM_CH > 16 || SEQ_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("heartbeat_grant_arbiter: unsupported parameter set");
    end

    state_t                 state_q;
    logic [CH_W-1:0]        last_q;
    logic [SEQ_WIDTH-1:0]   seq_q [NUM_CH];
    logic [NUM_CH-1:0]      grant_q;
    logic                   evt_valid_q;
    logic [CH_W-1:0]        evt_ch_q;
    logic [SEQ_WIDTH-1:0]   evt_seq_q;
    logic                   evt_drop_q;
    logic                   busy_q;
    logic [CH_W-1:0]        sel_s;
    logic                   found_s;

`ifdef HB_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0]      wait_q;
`endif

    // Round-robin pick: scan downward so the lowest offset above last_q wins.
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            int idx;
            idx     = (int'(last_q) + i) % NUM_CH;
            sel_s   = handshake[idx] ? CH_W'(idx) : sel_s;
            found_s = found_s | handshake[idx];
        end
    end

    // Arbiter FSM with all outputs registered; grant and drop are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= CH_W'(NUM_CH - 1);
            grant_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_seq_q   <= '0;
            evt_drop_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                seq_q[c] <= '0;
            end
`ifdef HB_ARB_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            grant_q    <= '0;
            evt_drop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_s) begin
                        evt_ch_q    <= sel_s;
                        evt_seq_q   <= seq_q[sel_s];
                        evt_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_EMIT;
`ifdef HB_ARB_TIMEOUT_EN
                        wait_q      <= '0;
`endif
                    end else begin
                        busy_q      <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (evt_ready) begin
                        evt_valid_q     <= 1'b0;
                        grant_q         <= NUM_CH'(1'b1) << evt_ch_q;
                        seq_q[evt_ch_q] <= seq_q[evt_ch_q] + SEQ_WIDTH'(1'b1);
                        last_q          <= evt_ch_q;
                        state_q         <= ST_GRANT;
`ifdef HB_ARB_TIMEOUT_EN
                    end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abandon the event but still grant so the counter keeps its cadence.
                        evt_valid_q     <= 1'b0;
                        evt_drop_q      <= 1'b1;
                        grant_q         <= NUM_CH'(1'b1) << evt_ch_q;
                        last_q          <= evt_ch_q;
                        state_q         <= ST_GRANT;
                    end else begin
                        wait_q          <= wait_q + WAIT_W'(1'b1);
`else
                    end else begin
                        evt_valid_q     <= 1'b1;
`endif
                    end
                end
                ST_GRANT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    evt_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_seq   = evt_seq_q;
    assign evt_drop  = evt_drop_q;
    assign busy      = busy_q;

endmodule

// File: doc/heartbeat_grant_arbiter.md
Name: heartbeat_grant_arbiter

Overview:
Grant-side end of the heartbeat handshake/grant protocol. Up to NUM_CH heartbeat period counters raise a level `handshake` when their period expires. This block arbitrates between them round-robin and emits one heartbeat event per served channel to the downstream packet builder over valid/ready. After the event is accepted, it returns a one-cycle `grant` to that counter, which restarts the counter's period. Sits between the per-channel period counters and the heartbeat frame transmitter.

Parameters:
NUM_CH, 4, number of requesting channels (1..16)
SEQ_WIDTH, 16, width of per-channel heartbeat sequence number
TIMEOUT_CYCLES, 1024, max cycles to wait for evt_ready (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
handshake  input  NUM_CH  level request per channel; high = period expired, awaiting grant
grant  output  NUM_CH  one-hot, one-cycle pulse to the served channel
evt_valid  output  1  heartbeat event valid
evt_ready  input  1  downstream accepts event
evt_ch  output  max(1,clog2(NUM_CH))  channel index of event
evt_seq  output  SEQ_WIDTH  sequence number of event for that channel
evt_drop  output  1  one-cycle pulse when an event is abandoned on timeout (tied 0 when feature off)
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: grant=0, evt_valid=0, evt_ch=0, evt_seq=0, evt_drop=0, busy=0. All per-channel sequence counters=0. Round-robin pointer last=NUM_CH-1, so channel 0 has first priority. State=IDLE.
- Reset mid-operation: abandon any pending event; no grant is issued. A counter stuck waiting keeps `handshake` high and is served after reset.
- FSM states: IDLE, EMIT, GRANT.
- IDLE:
  - If any handshake bit is high, select the first set bit searching upward from last+1, wrapping modulo NUM_CH.
  - Register evt_ch=sel and evt_seq=seq[sel]; set evt_valid=1; go to EMIT.
  - Request to evt_valid latency: 1 cycle.
- EMIT:
  - Hold evt_valid, evt_ch and evt_seq stable until evt_valid&&evt_ready.
  - On acceptance: evt_valid=0, grant[evt_ch]=1 next cycle, seq[evt_ch] increments (wraps from 2^SEQ_WIDTH-1 to 0), last=evt_ch; go to GRANT.
  - Deassertion of handshake[evt_ch] while in EMIT is ignored; the event completes normally.
- GRANT:
  - grant pulse is high for exactly this one cycle; then grant=0 and return to IDLE.
  - The granted counter drops handshake in the cycle after the grant, so IDLE re-arbitration never double-serves it.
- Minimum period per event with evt_ready tied high: 3 cycles (IDLE, EMIT, GRANT).
- Fairness: with all channels requesting continuously, service order is 0,1,2,3,0,...
- A channel is never granted without an accepted (or, with the feature, dropped) event.
- NUM_CH=1: pointer logic degenerates to always selecting channel 0.

Optional Feature:
Macro HB_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to EMIT.
  - If evt_ready has not been seen after TIMEOUT_CYCLES cycles in EMIT: deassert evt_valid, pulse evt_drop for one cycle, still issue grant (keeps heartbeat cadence), do not increment seq[evt_ch], update last, go to GRANT.
  - Acceptance on the final cycle takes precedence over timeout.
- Undefined: EMIT waits indefinitely; evt_drop is constant 0; no wait counter is present.

Test Plan:
- Reset, then handshake=4'b0001, evt_ready=1 -> evt_valid at cycle 1 with evt_ch=0, evt_seq=0; grant=4'b0001 for exactly 1 cycle; a second request then yields evt_seq=1.
- handshake=4'b1111 held with the bench model dropping each bit one cycle after its grant -> grants in order 0001,0010,0100,1000, each 1 cycle wide, 3 cycles apart.
- evt_ready held low for 20 cycles with channel 2 requesting -> evt_valid, evt_ch=2 and evt_seq stable all 20 cycles; no grant until the cycle after ready rises.
- Serve channel 1 65536 times with SEQ_WIDTH=16 -> evt_seq runs 65535 then 0; other channels' seq stay 0.
- Assert rst while in EMIT -> next cycle evt_valid=0, grant=0, seq cleared; held handshake is re-served after reset with evt_seq=0.
- With HB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, evt_ready=0 -> evt_drop pulse and grant pulse after 8 cycles in EMIT; next event for that channel carries the same evt_seq.
